parity_sweep_checker: RTL

//  Synthesizable exhaustive stimulus driver and response checker for the N-input XOR/parity gate blocks.

---
 rtl/parity_sweep_pkg.sv | 24 ++
 rtl/parity_sweep_checker_settle_timer.sv | 40 ++++
 rtl/parity_sweep_checker.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/parity_sweep_pkg.sv
// Shared types and helpers for the parity sweep checker: FSM state encoding,
// settle-counter width and the expected-parity function.
package parity_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

    // Widest stimulus vector parity_exp accepts; narrower vectors are zero-extended.
    localparam int PARITY_MAX_W = 32;

    function automatic int settle_cnt_w(input int settle_cyc);
        return $clog2(settle_cyc) + 1;
    endfunction

    // Zero-extension does not change a reduction XOR, so one width serves all N_IN.
    function automatic logic parity_exp(input logic [PARITY_MAX_W-1:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/parity_sweep_checker_settle_timer.sv
// Settle timer: counts cycles while enabled and pulses tc_o on the cycle the
// count reaches SETTLE_CYC-1, wrapping back to zero at the same edge.
module sweep_settle_timer
    import parity_sweep_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = settle_cnt_w(SETTLE_CYC);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = en_i && (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/parity_sweep_checker.sv
// Exhaustive parity-gate sweep driver/checker. Optional build macro
// PARITY_SWEEP_STOP_ON_ERR_EN ends the sweep on the first mismatch.
module parity_sweep_checker
    import parity_sweep_pkg::*;
#(
    parameter int N_IN       = 4,
    parameter int SETTLE_CYC = 2,
    parameter int ERR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              q_i,
    output logic [N_IN-1:0]   vec_o,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              first_err_vld,
    output logic [N_IN-1:0]   first_err_vec,
    output sweep_state_e      state_dbg_o
);

    localparam logic [N_IN-1:0]  VEC_LAST = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    sweep_state_e     state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fvld_q, fvld_d;
    logic [N_IN-1:0]  fvec_q, fvec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic tmr_clr;
    logic tmr_en;
    logic tmr_tc;
    logic mismatch;
    logic stop_now;

    sweep_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle (
        .clk     (clk),
        .rst     (rst),
        .clear_i (tmr_clr),
        .en_i    (tmr_en),
        .tc_o    (tmr_tc)
    );

    // q_i is only judged in SAMPLE, after the vector has been held for SETTLE_CYC cycles.
    assign mismatch = (state_q == ST_SAMPLE) &&
                      (q_i != parity_exp(PARITY_MAX_W'(vec_q)));

`ifdef PARITY_SWEEP_STOP_ON_ERR_EN
    assign stop_now = mismatch || (vec_q == VEC_LAST);
`else
    assign stop_now = (vec_q == VEC_LAST);
`endif

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        err_d   = err_q;
        fvld_d  = fvld_q;
        fvec_d  = fvec_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    vec_d   = '0;
                    err_d   = '0;
                    fvld_d  = 1'b0;
                    fvec_d  = '0;
                    tmr_clr = 1'b1;
                end
            end
            ST_DRIVE: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fvld_q) begin
                        fvld_d = 1'b1;
                        fvec_d = vec_q;
                    end
                end
                // All-ones is terminal: the vector never wraps back to zero.
                if (stop_now) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRIVE;
                    vec_d   = vec_q + 1'b1;
                    tmr_clr = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            fvld_q  <= 1'b0;
            fvec_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            fvld_q  <= fvld_d;
            fvec_q  <= fvec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign vec_o         = vec_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = done_q && (err_q == '0);
    assign err_cnt       = err_q;
    assign first_err_vld = fvld_q;
    assign first_err_vec = fvec_q;
    assign state_dbg_o   = state_q;

endmodule
